// File: rtl/frame_dump_tx.sv
// Streams the RGB framebuffer over UART (8N1, LSB first): a sync byte, then R,G,B per pixel
// in raster order, with the next pixel prefetched during the current pixel's blue byte.
module frame_dump_tx #(
    parameter int          W_RES        = 640,
    parameter int          H_RES        = 480,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          RD_LAT       = 1,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    output logic [10:0] rd_x,
    output logic [10:0] rd_y,
    input  logic [7:0]  rd_r,
    input  logic [7:0]  rd_g,
    input  logic [7:0]  rd_b,
    output logic        uart_tx,
    output logic        busy,
    output logic        done
);

    localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]      LAT      = 2'(RD_LAT);
    localparam logic [10:0]     X_LAST   = 11'(W_RES - 1);
    localparam logic [10:0]     Y_LAST   = 11'(H_RES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_SEND_R = 3'd2;
    localparam logic [2:0] S_SEND_G = 3'd3;
    localparam logic [2:0] S_SEND_B = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          tx_q, tx_d;
    logic [8:0]    sh_q, sh_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] clk_q, clk_d;
    logic [10:0]   x_q, x_d, y_q, y_d;
    logic          pend_q, pend_d;
    logic [1:0]    lat_q, lat_d;
    logic [7:0]    pre_r_q, pre_r_d, pre_g_q, pre_g_d, pre_b_q, pre_b_d;
    logic [7:0]    hold_g_q, hold_g_d, hold_b_q, hold_b_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic          active_s;
    logic          byte_end_s;
    logic          load_s;
    logic [7:0]    load_byte_s;

    assign active_s   = (state_q == S_HDR) || (state_q == S_SEND_R) ||
                        (state_q == S_SEND_G) || (state_q == S_SEND_B);
    assign byte_end_s = active_s && (clk_q == CLK_LAST) && (bit_q == 4'd9);

    // Next-state logic: bit serializer, read-latency fetch timer and byte sequencer.
    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        sh_d        = sh_q;
        bit_d       = bit_q;
        clk_d       = clk_q;
        x_d         = x_q;
        y_d         = y_q;
        pend_d      = pend_q;
        lat_d       = lat_q;
        pre_r_d     = pre_r_q;
        pre_g_d     = pre_g_q;
        pre_b_d     = pre_b_q;
        hold_g_d    = hold_g_q;
        hold_b_d    = hold_b_q;
        last_d      = last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load_s      = 1'b0;
        load_byte_s = 8'h00;

        if (active_s) begin
            if (clk_q == CLK_LAST) begin
                clk_d = {CW{1'b0}};
                if (bit_q != 4'd9) begin
                    tx_d  = sh_q[0];
                    sh_d  = {1'b1, sh_q[8:1]};
                    bit_d = bit_q + 4'd1;
                end else begin
                    bit_d = bit_q;
                end
            end else begin
                clk_d = clk_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            clk_d = clk_q;
        end

        // Fetch runs beside the byte sequencer so the pipeline never stalls the line.
        if (pend_q) begin
            if (lat_q == 2'd0) begin
                pre_r_d = rd_r;
                pre_g_d = rd_g;
                pre_b_d = rd_b;
                pend_d  = 1'b0;
            end else begin
                lat_d = lat_q - 2'd1;
            end
        end else begin
            pend_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_HDR;
                    busy_d      = 1'b1;
                    load_s      = 1'b1;
                    load_byte_s = HEADER;
                    x_d         = 11'd0;
                    y_d         = 11'd0;
                    pend_d      = 1'b1;
                    lat_d       = LAT;
                    last_d      = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HDR: begin
                if (byte_end_s) begin
                    state_d     = S_SEND_R;
                    load_s      = 1'b1;
                    load_byte_s = pre_r_q;
                    hold_g_d    = pre_g_q;
                    hold_b_d    = pre_b_q;
                end else begin
                    state_d = S_HDR;
                end
            end
            S_SEND_R: begin
                if (byte_end_s) begin
                    state_d     = S_SEND_G;
                    load_s      = 1'b1;
                    load_byte_s = hold_g_q;
                end else begin
                    state_d = S_SEND_R;
                end
            end
            S_SEND_G: begin
                if (byte_end_s) begin
                    state_d     = S_SEND_B;
                    load_s      = 1'b1;
                    load_byte_s = hold_b_q;
                    pend_d      = 1'b1;
                    lat_d       = LAT;
                    if (x_q == X_LAST) begin
                        x_d = 11'd0;
                        if (y_q == Y_LAST) begin
                            y_d    = 11'd0;
                            last_d = 1'b1;
                        end else begin
                            y_d = y_q + 11'd1;
                        end
                    end else begin
                        x_d = x_q + 11'd1;
                    end
                end else begin
                    state_d = S_SEND_G;
                end
            end
            S_SEND_B: begin
                if (byte_end_s) begin
                    if (last_q) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        tx_d    = 1'b1;
                        last_d  = 1'b0;
                    end else begin
                        state_d     = S_SEND_R;
                        load_s      = 1'b1;
                        load_byte_s = pre_r_q;
                        hold_g_d    = pre_g_q;
                        hold_b_d    = pre_b_q;
                    end
                end else begin
                    state_d = S_SEND_B;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase

        if (load_s) begin
            tx_d  = 1'b0;
            sh_d  = {1'b1, load_byte_s};
            bit_d = 4'd0;
            clk_d = {CW{1'b0}};
        end else begin
            sh_d = sh_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tx_q     <= 1'b1;
            sh_q     <= 9'h1FF;
            bit_q    <= 4'd0;
            clk_q    <= {CW{1'b0}};
            x_q      <= 11'd0;
            y_q      <= 11'd0;
            pend_q   <= 1'b0;
            lat_q    <= 2'd0;
            pre_r_q  <= 8'h00;
            pre_g_q  <= 8'h00;
            pre_b_q  <= 8'h00;
            hold_g_q <= 8'h00;
            hold_b_q <= 8'h00;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_q     <= tx_d;
            sh_q     <= sh_d;
            bit_q    <= bit_d;
            clk_q    <= clk_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pend_q   <= pend_d;
            lat_q    <= lat_d;
            pre_r_q  <= pre_r_d;
            pre_g_q  <= pre_g_d;
            pre_b_q  <= pre_b_d;
            hold_g_q <= hold_g_d;
            hold_b_q <= hold_b_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_x    = x_q;
    assign rd_y    = y_q;

endmodule

// File: tb/tb_frame_dump_tx.sv
// Bench for frame_dump_tx on a 4x2 frame: two instances (read latency 1 and 3) run side by
// side; a UART decoder monitor pops expected bytes from per-instance scoreboard queues.
module tb_frame_dump_tx;
    localparam int CPB       = 4;
    localparam int BYTE_CYC  = 10 * CPB;
    localparam int FRAME_CYC = 25 * BYTE_CYC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start;
    logic [10:0] rd_x0, rd_y0, rd_x1, rd_y1;
    logic [7:0]  r0, g0, b0, r1, g1, b1;
    logic        tx0, busy0, done0, tx1, busy1, done1;
    logic        tx_a [2];
    logic        busy_a [2];
    logic        done_a [2];

    assign tx_a[0] = tx0;  assign busy_a[0] = busy0;  assign done_a[0] = done0;
    assign tx_a[1] = tx1;  assign busy_a[1] = busy1;  assign done_a[1] = done1;

    frame_dump_tx #(.W_RES(4), .H_RES(2), .CLKS_PER_BIT(CPB), .RD_LAT(1), .HEADER(8'hA5)) dut0 (
        .CLOCK_50(clk), .reset(reset), .start(start), .rd_x(rd_x0), .rd_y(rd_y0),
        .rd_r(r0), .rd_g(g0), .rd_b(b0), .uart_tx(tx0), .busy(busy0), .done(done0));

    frame_dump_tx #(.W_RES(4), .H_RES(2), .CLKS_PER_BIT(CPB), .RD_LAT(3), .HEADER(8'hA5)) dut1 (
        .CLOCK_50(clk), .reset(reset), .start(start), .rd_x(rd_x1), .rd_y(rd_y1),
        .rd_r(r1), .rd_g(g1), .rd_b(b1), .uart_tx(tx1), .busy(busy1), .done(done1));

    // Framebuffer models with 1 and 3 cycles of read latency.
    logic [21:0] p0;
    logic [21:0] p1 [3];
    always @(posedge clk) begin
        p0    <= {rd_x0, rd_y0};
        p1[0] <= {rd_x1, rd_y1};
        p1[1] <= p1[0];
        p1[2] <= p1[1];
    end

    function automatic logic [23:0] pix(input logic [21:0] a);
        logic [10:0] x, y;
        x = a[21:11];
        y = a[10:0];
        return {x[3:0], y[3:0], 8'h10 + x[7:0], 8'hF0 - y[7:0]};
    endfunction

    assign {r0, g0, b0} = pix(p0);
    assign {r1, g1, b1} = pix(p1[2]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed stream: header, then (R,G,B) for (x,y) in raster order.
    logic [7:0] exp_tab [25] = '{8'hA5,
        8'h00, 8'h10, 8'hF0,  8'h10, 8'h11, 8'hF0,  8'h20, 8'h12, 8'hF0,  8'h30, 8'h13, 8'hF0,
        8'h01, 8'h10, 8'hEF,  8'h11, 8'h11, 8'hEF,  8'h21, 8'h12, 8'hEF,  8'h31, 8'h13, 8'hEF};

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         n_chk, n_err, frame_base;
    int         rx_cnt [2];
    int         bcnt [2];
    int         dcnt [2];
    int         dcyc [2];
    logic       rx_act [2];
    logic       prev_tx [2];
    logic [7:0] rx_byte [2];
    logic [7:0] hdr_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input int i);
        logic [7:0] e;
        if (i == 0) begin
            chk("dut0_byte_expected", {31'd0, q0.size() != 0}, 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("dut0_byte", {24'd0, rx_byte[0]}, {24'd0, e});
            end
        end else begin
            chk("dut1_byte_expected", {31'd0, q1.size() != 0}, 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("dut1_byte", {24'd0, rx_byte[1]}, {24'd0, e});
            end
        end
    endtask

    // One negedge of monitoring for instance i: bit alignment, busy length, done, UART decode.
    task automatic mon(input int i);
        if (busy_a[i] && (tx_a[i] !== prev_tx[i]))
            chk("bit_edge_align", (cyc - frame_base) % CPB, 32'd0);
        prev_tx[i] = tx_a[i];
        if (busy_a[i]) begin
            bcnt[i]++;
        end else if (done_a[i]) begin
            dcnt[i]++;
            dcyc[i] = cyc;
            chk("busy_len", bcnt[i], FRAME_CYC);
            bcnt[i] = 0;
        end else begin
            bcnt[i] = 0;
        end
        if (!busy_a[i]) begin
            rx_act[i] = 1'b0;
        end else if (!rx_act[i]) begin
            if (tx_a[i] == 1'b0) begin
                rx_act[i] = 1'b1;
                rx_cnt[i] = 0;
                chk("byte_gap", (cyc - frame_base) % BYTE_CYC, 32'd0);
            end
        end else begin
            rx_cnt[i]++;
            if (rx_cnt[i] == 2) begin
                chk("start_bit", {31'd0, tx_a[i]}, 32'd0);
            end else if (rx_cnt[i] >= 6 && rx_cnt[i] <= 34 && (rx_cnt[i] % 4) == 2) begin
                rx_byte[i][(rx_cnt[i] - 6) / 4] = tx_a[i];
            end else if (rx_cnt[i] == 38) begin
                chk("stop_bit", {31'd0, tx_a[i]}, 32'd1);
                rx_act[i] = 1'b0;
                pop_cmp(i);
            end
        end
    endtask

    task automatic launch();
        @(negedge clk);
        start      = 1'b1;
        frame_base = cyc + 1;
        for (int k = 0; k < 25; k++) begin
            q0.push_back(exp_tab[k]);
            q1.push_back(exp_tab[k]);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int base);
        int k;
        k = 0;
        while (done0 !== 1'b1 && k < 1200) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {31'd0, done0}, 32'd1);
        chk("done_cycle", cyc, base + FRAME_CYC);
        chk("done_busy_low", {31'd0, busy0}, 32'd0);
        repeat (3) @(negedge clk);
        chk("dut1_done_cycle", dcyc[1], base + FRAME_CYC);
        chk("q0_drained", q0.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        n_chk = 0;
        n_err = 0;
        frame_base = 0;
        hdr_v = 8'hA5;
        for (int i = 0; i < 2; i++) begin
            rx_cnt[i] = 0; bcnt[i] = 0; dcnt[i] = 0; dcyc[i] = 0;
            rx_act[i] = 1'b0; prev_tx[i] = 1'b1; rx_byte[i] = 8'h00;
        end
        fork
            forever begin
                @(negedge clk);
                mon(0);
                mon(1);
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx0}, 32'd1);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_rd_x", {21'd0, rd_x0}, 32'd0);
        chk("rst_rd_y", {21'd0, rd_y0}, 32'd0);
        chk("rst_tx1", {31'd0, tx1}, 32'd0 + 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full dump with header bit checks and an ignored start at cycle 100.
        launch();
        chk("hdr_start_tx", {31'd0, tx0}, 32'd0);
        chk("hdr_start_busy", {31'd0, busy0}, 32'd1);
        chk("hdr_start_tx1", {31'd0, tx1}, 32'd0);
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            repeat (4) @(negedge clk);
            chk("hdr_bit", {31'd0, tx0}, {31'd0, hdr_v[j]});
        end
        repeat (67) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(frame_base);
        chk("done_count0_f1", dcnt[0], 32'd1);
        chk("done_count1_f1", dcnt[1], 32'd1);
        repeat (50) @(negedge clk);
        chk("no_requeue_done", dcnt[0], 32'd1);
        chk("no_requeue_busy", {31'd0, busy0}, 32'd0);

        // Reset mid-frame.
        launch();
        repeat (299) @(negedge clk);
        chk("pre_reset_rd_x", {21'd0, rd_x0}, 32'd2);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_tx", {31'd0, tx0}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy0}, 32'd0);
        chk("mid_rst_done", {31'd0, done0}, 32'd0);
        chk("mid_rst_rd_x", {21'd0, rd_x0}, 32'd0);
        chk("mid_rst_rd_y", {21'd0, rd_y0}, 32'd0);
        chk("mid_rst_busy1", {31'd0, busy1}, 32'd0);
        repeat (1100) @(negedge clk);
        chk("no_done_after_rst0", dcnt[0], 32'd1);
        chk("no_done_after_rst1", dcnt[1], 32'd1);
        chk("idle_tx_after_rst", {31'd0, tx0}, 32'd1);

        // start and reset together: reset wins.
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("start_rst_busy", {31'd0, busy0}, 32'd0);
        chk("start_rst_tx", {31'd0, tx0}, 32'd1);

        // Fresh complete dump.
        launch();
        wait_done(frame_base);
        chk("done_count0_f3", dcnt[0], 32'd2);
        chk("done_count1_f3", dcnt[1], 32'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
